dmem_io_ctrl: RTL and testbench
===============================

// Module: dmem_io_ctrl
// PURPOSE
//   Parametrised data memory plus memory-mapped I/O unit for the single-cycle and next-generation cores.
//   Decodes a DBITS-wide byte address into word RAM or I/O registers: HEX, LEDR, KEY, SW and KEY edge-capture.
//   Adds input synchronisers, debouncing and sticky KEY edge capture with a write-1-to-clear interrupt.
//   Sits between the ALU result/rs2 data and the register-file writeback mux.
// PARAMETERS
//   DBITS            32            data and address width
//   DMEM_ADDR_BITS   11            log2 of RAM depth in words
//   DMEM_INIT_FILE   "Data.mif"    RAM init image
//   HEX_BITS         16            hex display register width
//   LEDR_BITS        10            LED register width
//   KEY_BITS         4             push-button count; pins are active-low
//   SW_BITS          10            slide switch count
//   DEBOUNCE_CYCLES  16            stable cycles needed before a debounced input changes; minimum 2
//   ADDR_HEX  32'hF0000000 | ADDR_LEDR 32'hF0000004 | ADDR_KEY 32'hF0000010
//   ADDR_SW   32'hF0000014 | ADDR_KCAP 32'hF0000018
// PORTS
//   clk       in   1          core clock; all state updates on the rising edge
//   reset     in   1          asynchronous, active-low reset
//   wr_en     in   1          store strobe, sampled at clk edge
//   addr      in   DBITS      byte address; bits [1:0] ignored
//   wdata     in   DBITS      store data
//   rdata     out  DBITS      load data, combinational from addr
//   key_in    in   KEY_BITS   raw KEY pins, 0 = pressed
//   sw_in     in   SW_BITS    raw switch pins
//   hex_out   out  HEX_BITS   HEX register
//   ledr_out  out  LEDR_BITS  LEDR register
//   key_irq   out  1          OR-reduction of the KEY capture register
// BEHAVIOUR
//   Decode
//   - addr[DBITS-1:28] == 4'hF selects I/O; any other value selects RAM.
//   - RAM word index = addr[DMEM_ADDR_BITS+1:2]; upper bits ignored, so addresses wrap.
//   - Unmapped I/O reads return 0; unmapped I/O writes are ignored.
//   - Writes to KEY and SW are ignored.
//   RAM
//   - Write is synchronous: at the edge with wr_en=1 and RAM selected, word <= wdata.
//   - Read is asynchronous. Read-during-write to the same word returns the old data until the edge.
//   - RAM contents are not affected by reset.
//   HEX/LEDR
//   - A write loads wdata[HEX_BITS-1:0] or wdata[LEDR_BITS-1:0].
//   - The new value appears on hex_out/ledr_out after that edge.
//   - Reads return the register, zero-extended.
//   Input path (KEY and SW each have independent logic)
//   - 2-flop synchroniser feeding a debounced register (db) and a counter.
//   - Each edge, if sync == db: cnt <= 0.
//   - Each edge, else if cnt == DEBOUNCE_CYCLES-1: db <= sync and cnt <= 0.
//   - Otherwise cnt <= cnt + 1.
//   - A clean input change reaches db at edge 2+DEBOUNCE_CYCLES.
//   - A glitch shorter than DEBOUNCE_CYCLES never changes db.
//   - KEY db is stored inverted (1 = pressed). A KEY read returns db zero-extended; an SW read likewise.
//   KEY capture (kcap, KEY_BITS)
//   - kcap[i] is set on the same edge that db[i] goes 0->1 (press).
//   - Writing ADDR_KCAP clears each kcap bit where wdata is 1 (W1C).
//   - If a set and a clear hit the same bit on the same edge, the set wins.
//   - A read of ADDR_KCAP returns kcap; key_irq = |kcap, combinational from kcap.
//   Reset (asynchronous, while reset=0)
//   - hex_out=0, ledr_out=0, kcap=0, key_irq=0.
//   - KEY sync/db = released; SW sync/db = 0; all counters = 0.
//   - Reset mid-debounce discards the count; the input must then be stable a full 2+DEBOUNCE_CYCLES cycles after release.
//   - rdata for an I/O address reflects the reset register values immediately.
// TESTING
//   T1 RAM:   store 0xDEADBEEF @0x100, then load @0x100 and @0x100+(4<<DMEM_ADDR_BITS).
//             -> both return 0xDEADBEEF; same-cycle read returns old word.
//   T2 HEX/LEDR: store 0x12345678 to ADDR_HEX and 0xFFF to ADDR_LEDR.
//             -> hex_out=0x5678 and ledr_out=0x3FF after the edge; loads return 0x5678 and 0x3FF.
//   T3 KEY debounce (DEBOUNCE_CYCLES=16): key_in=4'b1110 held stable.
//             -> KEY read = 1 and kcap=1 at edge 18; key_irq high.
//             -> A 10-cycle glitch instead leaves KEY read = 0 and kcap = 0.
//   T4 W1C:   kcap=4'b0101; store 4'b0001 to ADDR_KCAP -> kcap=4'b0100.
//             -> With a new KEY0 press on that same edge, kcap=4'b0101.
//   T5 SW:    sw_in=0x2AA stable -> SW read=0x2AA from edge 18.
//             -> Store to ADDR_SW and to 0xF0000020 is ignored; load of 0xF0000020 returns 0.
//   T6 Reset: assert reset mid-debounce and with hex_out=0x5678.
//             -> hex_out, kcap and key_irq clear with no clock; debounce restarts from 0 after release.

Source files
------------

// File: rtl/dmem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_io_ctrl (+ dmem_io_debounce)
// Brief   : Word RAM plus memory-mapped HEX/LEDR/KEY/SW/KEY-capture registers.
// Revision: 1.0 - initial release
// ============================================================================

module dmem_io_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o
);
  localparam int                CNT_BITS = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]    sync1_q, sync2_q, db_q, db_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // One shared counter per group: any difference between sync and db keeps it running.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = db_d & ~db_q;
endmodule

module dmem_io_ctrl #(
  parameter int               DBITS           = 32,
  parameter int               DMEM_ADDR_BITS  = 11,
  parameter                   DMEM_INIT_FILE  = "Data.mif",
  parameter int               HEX_BITS        = 16,
  parameter int               LEDR_BITS       = 10,
  parameter int               KEY_BITS        = 4,
  parameter int               SW_BITS         = 10,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCAP       = 32'hF0000018
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     addr,
  input  logic [DBITS-1:0]     wdata,
  output logic [DBITS-1:0]     rdata,
  input  logic [KEY_BITS-1:0]  key_in,
  input  logic [SW_BITS-1:0]   sw_in,
  output logic [HEX_BITS-1:0]  hex_out,
  output logic [LEDR_BITS-1:0] ledr_out,
  output logic                 key_irq
);
  logic                      io_sel;
  logic                      hit_hex, hit_ledr, hit_key, hit_sw, hit_kcap;
  logic [DMEM_ADDR_BITS-1:0] word_idx;
  logic [HEX_BITS-1:0]       hex_q;
  logic [LEDR_BITS-1:0]      ledr_q;
  logic [KEY_BITS-1:0]       kcap_q, kcap_d, kcap_clr;
  logic [KEY_BITS-1:0]       key_db, key_rise;
  logic [SW_BITS-1:0]        sw_db, sw_rise;
  logic                      unused_bits;

  (* ram_init_file = DMEM_INIT_FILE *)
  logic [DBITS-1:0] mem_q [2**DMEM_ADDR_BITS];

  assign io_sel   = &addr[DBITS-1:28];
  assign word_idx = addr[DMEM_ADDR_BITS+1:2];
  assign hit_hex  = io_sel && (addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2]);
  assign hit_ledr = io_sel && (addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]);
  assign hit_key  = io_sel && (addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2]);
  assign hit_sw   = io_sel && (addr[DBITS-1:2] == ADDR_SW[DBITS-1:2]);
  assign hit_kcap = io_sel && (addr[DBITS-1:2] == ADDR_KCAP[DBITS-1:2]);
  assign unused_bits = ^{addr[1:0], sw_rise};

  always_ff @(posedge clk) begin
    if (wr_en && !io_sel) begin
      mem_q[word_idx] <= wdata;
    end
  end

  // KEY pins are active-low; invert ahead of the synchroniser so db reads 1 = pressed.
  dmem_io_debounce #(
    .WIDTH          (KEY_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk    (clk),
    .rst_n_i(reset),
    .raw_i  (~key_in),
    .db_o   (key_db),
    .rise_o (key_rise)
  );

  dmem_io_debounce #(
    .WIDTH          (SW_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk    (clk),
    .rst_n_i(reset),
    .raw_i  (sw_in),
    .db_o   (sw_db),
    .rise_o (sw_rise)
  );

  // Set after clear so a press landing on a W1C edge is never lost.
  assign kcap_clr = (wr_en && hit_kcap) ? wdata[KEY_BITS-1:0] : '0;
  assign kcap_d   = (kcap_q & ~kcap_clr) | key_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q  <= '0;
      ledr_q <= '0;
      kcap_q <= '0;
    end else begin
      if (wr_en && hit_hex)  hex_q  <= wdata[HEX_BITS-1:0];
      if (wr_en && hit_ledr) ledr_q <= wdata[LEDR_BITS-1:0];
      kcap_q <= kcap_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (!io_sel)       rdata = mem_q[word_idx];
    else if (hit_hex)  rdata = DBITS'(hex_q);
    else if (hit_ledr) rdata = DBITS'(ledr_q);
    else if (hit_key)  rdata = DBITS'(key_db);
    else if (hit_sw)   rdata = DBITS'(sw_db);
    else if (hit_kcap) rdata = DBITS'(kcap_q);
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
  assign key_irq  = |kcap_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_io_ctrl
// Brief   : Directed self-checking bench for dmem_io_ctrl (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_io_ctrl;
  localparam logic [31:0] A_HEX  = 32'hF0000000;
  localparam logic [31:0] A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_SW   = 32'hF0000014;
  localparam logic [31:0] A_KCAP = 32'hF0000018;
  localparam logic [31:0] A_UNMP = 32'hF0000020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  key_in = 4'hF;
  logic [9:0]  sw_in = '0;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic        key_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  dmem_io_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .key_in  (key_in),
    .sw_in   (sw_in),
    .hex_out (hex_out),
    .ledr_out(ledr_out),
    .key_irq (key_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cload(input string tag, input logic [31:0] a, input logic [31:0] exp);
    wr_en = 1'b0;
    addr  = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_hex_out", 32'(hex_out), 32'h0);
    check("rst_ledr_out", 32'(ledr_out), 32'h0);
    check("rst_key_irq", 32'(key_irq), 32'h0);
    cload("rst_key_rd", A_KEY, 32'h0);
    cload("rst_kcap_rd", A_KCAP, 32'h0);
    reset = 1'b1;
    tick();

    // T1 RAM, read-during-write, aliasing
    store(32'h100, 32'h11111111);
    addr = 32'h100; wdata = 32'hDEADBEEF; wr_en = 1'b1;
    #1;
    check("ram_rdw_old", rdata, 32'h11111111);
    tick();
    wr_en = 1'b0;
    cload("ram_new", 32'h100, 32'hDEADBEEF);
    cload("ram_alias_rd", 32'h2100, 32'hDEADBEEF);
    store(32'h2104, 32'hCAFEF00D);
    cload("ram_alias_wr", 32'h104, 32'hCAFEF00D);

    // T2 HEX / LEDR
    addr = A_HEX; wdata = 32'h12345678; wr_en = 1'b1;
    #1;
    check("hex_before_edge", 32'(hex_out), 32'h0);
    tick();
    wr_en = 1'b0;
    check("hex_out", 32'(hex_out), 32'h5678);
    store(A_LEDR, 32'hFFF);
    check("ledr_out", 32'(ledr_out), 32'h3FF);
    cload("hex_rd", A_HEX, 32'h5678);
    cload("ledr_rd", A_LEDR, 32'h3FF);

    // T3 glitch one cycle short of the debounce window, then a clean press
    key_in = 4'b1110; tick(15);
    key_in = 4'hF;    tick(20);
    cload("glitch_key_rd", A_KEY, 32'h0);
    cload("glitch_kcap_rd", A_KCAP, 32'h0);
    check("glitch_irq", 32'(key_irq), 32'h0);
    key_in = 4'b1110; tick(17);
    cload("key_edge17", A_KEY, 32'h0);
    check("irq_edge17", 32'(key_irq), 32'h0);
    tick(1);
    cload("key_edge18", A_KEY, 32'h1);
    cload("kcap_edge18", A_KCAP, 32'h1);
    check("irq_edge18", 32'(key_irq), 32'h1);

    // T4 W1C and set-wins
    key_in = 4'b1010; tick(18);
    cload("kcap_0101", A_KCAP, 32'h5);
    key_in = 4'hF; tick(20);
    cload("key_released", A_KEY, 32'h0);
    cload("kcap_sticky", A_KCAP, 32'h5);
    store(A_KCAP, 32'h1);
    cload("kcap_w1c", A_KCAP, 32'h4);
    check("irq_after_w1c", 32'(key_irq), 32'h1);
    key_in = 4'b1110; tick(17);
    store(A_KCAP, 32'h1);
    cload("kcap_set_wins", A_KCAP, 32'h5);
    store(A_KCAP, 32'hF);
    cload("kcap_clr_all", A_KCAP, 32'h0);
    check("irq_clr_all", 32'(key_irq), 32'h0);

    // T5 SW, ignored writes, unmapped I/O
    store(32'h20, 32'hA5A5A5A5);
    sw_in = 10'h2AA; tick(17);
    cload("sw_edge17", A_SW, 32'h0);
    tick(1);
    cload("sw_edge18", A_SW, 32'h2AA);
    store(A_SW, 32'h123);
    cload("sw_wr_ignored", A_SW, 32'h2AA);
    store(A_KEY, 32'hF);
    cload("key_wr_ignored", A_KEY, 32'h1);
    store(A_UNMP, 32'h12345678);
    cload("unmapped_rd", A_UNMP, 32'h0);
    cload("unmapped_no_ram", 32'h20, 32'hA5A5A5A5);
    check("hex_kept", 32'(hex_out), 32'h5678);
    check("ledr_kept", 32'(ledr_out), 32'h3FF);

    // T6 asynchronous reset mid-debounce
    key_in = 4'b1101; tick(18);
    cload("kcap_key1", A_KCAP, 32'h2);
    check("irq_key1", 32'(key_irq), 32'h1);
    sw_in = 10'h155; tick(10);
    #2 reset = 1'b0;
    #1;
    check("arst_hex_out", 32'(hex_out), 32'h0);
    check("arst_ledr_out", 32'(ledr_out), 32'h0);
    check("arst_irq", 32'(key_irq), 32'h0);
    cload("arst_kcap_rd", A_KCAP, 32'h0);
    cload("arst_key_rd", A_KEY, 32'h0);
    cload("arst_sw_rd", A_SW, 32'h0);
    tick(3);
    reset = 1'b1;
    tick(17);
    cload("rel_sw_edge17", A_SW, 32'h0);
    cload("rel_kcap_edge17", A_KCAP, 32'h0);
    tick(1);
    cload("rel_sw_edge18", A_SW, 32'h155);
    cload("rel_key_edge18", A_KEY, 32'h2);
    cload("rel_kcap_edge18", A_KCAP, 32'h2);
    cload("ram_survives_rst", 32'h100, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
